// File: rtl/branch_cond_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_ctrl
// Description : Branch-resolution sequencer for the multicycle datapath.
//               Steps a branch through COMPARE, FLAGS and RESOLVE, registers
//               the ALU comparison flags, and pulses the PC conditional-write
//               enable together with the matching 2-bit condition select.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_ctrl #(
    parameter logic [5:0] OP_BEQ  = 6'h04,
    parameter logic [5:0] OP_BNE  = 6'h05,
    parameter logic [5:0] OP_BLE  = 6'h06,
    parameter logic [5:0] OP_BGT  = 6'h07,
    parameter logic [2:0] ALU_SUB = 3'b010
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       alu_lt,
    input  logic       alu_eq,
    output logic [2:0] alu_op,
    output logic [1:0] PCWriteCondMux,
    output logic       PCWriteCond,
    output logic       ZeroFio,
    output logic       MaiorFio,
    output logic       MenorFio,
    output logic       IgualFio,
    output logic       busy,
    output logic       done,
    output logic       taken,
    output logic       illegal
);

    // State encoding; codes 6 and 7 are unused and fall back to IDLE.
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_COMPARE = 3'd1;
    localparam logic [2:0] c_ST_FLAGS   = 3'd2;
    localparam logic [2:0] c_ST_RESOLVE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_ERR     = 3'd5;

    // Condition select values understood by the PC write-condition mux.
    localparam logic [1:0] c_SEL_NZ = 2'b00;
    localparam logic [1:0] c_SEL_Z  = 2'b01;
    localparam logic [1:0] c_SEL_GT = 2'b10;
    localparam logic [1:0] c_SEL_LE = 2'b11;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_sel;
    logic [1:0] w_op_sel;
    logic       w_is_branch;
    logic       w_taken;

    logic [2:0] r_alu_op;
    logic [1:0] r_mux;
    logic       r_pcw;
    logic       r_zero;
    logic       r_gt;
    logic       r_lt;
    logic       r_eq;
    logic       r_busy;
    logic       r_done;
    logic       r_taken;
    logic       r_illegal;

    // Decode the opcode into a branch/non-branch flag and its condition select.
    always_comb begin
        w_is_branch = 1'b1;
        w_op_sel    = c_SEL_NZ;
        case (opcode)
            OP_BNE:  w_op_sel = c_SEL_NZ;
            OP_BEQ:  w_op_sel = c_SEL_Z;
            OP_BGT:  w_op_sel = c_SEL_GT;
            OP_BLE:  w_op_sel = c_SEL_LE;
            default: w_is_branch = 1'b0;
        endcase
    end

    // Evaluate the branch condition from the captured flags (used in RESOLVE).
    always_comb begin
        w_taken = 1'b0;
        case (r_sel)
            c_SEL_NZ: w_taken = ~r_zero;
            c_SEL_Z:  w_taken = r_zero;
            c_SEL_GT: w_taken = r_gt;
            c_SEL_LE: w_taken = r_lt | r_eq;
            default:  w_taken = 1'b0;
        endcase
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = w_is_branch ? c_ST_COMPARE : c_ST_ERR;
                end
            end
            c_ST_COMPARE: w_next_state = c_ST_FLAGS;
            c_ST_FLAGS:   w_next_state = c_ST_RESOLVE;
            c_ST_RESOLVE: w_next_state = c_ST_DONE;
            c_ST_DONE:    w_next_state = c_ST_IDLE;
            c_ST_ERR:     w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered outputs, decoded from the state being entered so that each
    // output is valid for the whole cycle of its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_op  <= 3'b000;
            r_mux     <= 2'b00;
            r_pcw     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_alu_op  <= (w_next_state == c_ST_COMPARE) ? ALU_SUB : 3'b000;
            r_pcw     <= (w_next_state == c_ST_RESOLVE);
            r_busy    <= (w_next_state != c_ST_IDLE);
            r_done    <= (w_next_state == c_ST_DONE);
            r_taken   <= (w_next_state == c_ST_DONE) ? w_taken : 1'b0;
            r_illegal <= (w_next_state == c_ST_ERR);
            // The select holds its last value outside RESOLVE.
            if (w_next_state == c_ST_RESOLVE) begin
                r_mux <= r_sel;
            end
        end
    end

    // Latch the condition select when a branch is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel <= 2'b00;
        end else if ((r_state == c_ST_IDLE) && start && w_is_branch) begin
            r_sel <= w_op_sel;
        end
    end

    // Capture the ALU comparison flags at the end of FLAGS only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_gt   <= 1'b0;
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
        end else if (r_state == c_ST_FLAGS) begin
            r_zero <= alu_zero;
            r_gt   <= alu_gt;
            r_lt   <= alu_lt;
            r_eq   <= alu_eq;
        end
    end

    assign alu_op         = r_alu_op;
    assign PCWriteCondMux = r_mux;
    assign PCWriteCond    = r_pcw;
    assign ZeroFio        = r_zero;
    assign MaiorFio       = r_gt;
    assign MenorFio       = r_lt;
    assign IgualFio       = r_eq;
    assign busy           = r_busy;
    assign done           = r_done;
    assign taken          = r_taken;
    assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_cond_ctrl
// Description : Self-checking bench for branch_cond_ctrl. A transaction-level
//               reference model tracks the age of the accepted request and
//               predicts every output each cycle; directed sequences pin the
//               model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cond_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       alu_zero;
    logic       alu_gt;
    logic       alu_lt;
    logic       alu_eq;
    logic [2:0] alu_op;
    logic [1:0] PCWriteCondMux;
    logic       PCWriteCond;
    logic       ZeroFio;
    logic       MaiorFio;
    logic       MenorFio;
    logic       IgualFio;
    logic       busy;
    logic       done;
    logic       taken;
    logic       illegal;

    int n_cmp = 0;
    int n_bad = 0;

    branch_cond_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .opcode         (opcode),
        .alu_zero       (alu_zero),
        .alu_gt         (alu_gt),
        .alu_lt         (alu_lt),
        .alu_eq         (alu_eq),
        .alu_op         (alu_op),
        .PCWriteCondMux (PCWriteCondMux),
        .PCWriteCond    (PCWriteCond),
        .ZeroFio        (ZeroFio),
        .MaiorFio       (MaiorFio),
        .MenorFio       (MenorFio),
        .IgualFio       (IgualFio),
        .busy           (busy),
        .done           (done),
        .taken          (taken),
        .illegal        (illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the age of the request in flight (0 = none) decides
    // every output. Updated on each rising edge from the driven inputs.
    // ------------------------------------------------------------------
    int         m_age   = 0;
    bit         m_err   = 1'b0;
    bit         m_valid = 1'b0;
    logic [5:0] m_op    = 6'h00;
    logic [3:0] m_flags = 4'h0;   // {zero, gt, lt, eq}
    logic [2:0] e_alu_op  = 3'b000;
    logic [1:0] e_mux     = 2'b00;
    logic       e_pcw     = 1'b0;
    logic       e_busy    = 1'b0;
    logic       e_done    = 1'b0;
    logic       e_taken   = 1'b0;
    logic       e_illegal = 1'b0;

    function automatic logic [1:0] sel_of(input logic [5:0] op);
        case (op)
            6'h05:   return 2'b00;
            6'h04:   return 2'b01;
            6'h07:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic outcome(input logic [5:0] op, input logic [3:0] f);
        case (op)
            6'h04:   return f[3];
            6'h05:   return ~f[3];
            6'h07:   return f[2];
            default: return f[1] | f[0];
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1'b1;
            m_age   = 0;
            m_err   = 1'b0;
            m_flags = 4'h0;
            e_mux   = 2'b00;
        end else begin
            // Flags are sampled on the edge that ends the second cycle of a branch.
            if (!m_err && m_age == 2) m_flags = {alu_zero, alu_gt, alu_lt, alu_eq};
            if (m_age == 0) begin
                if (start) begin
                    m_age = 1;
                    m_op  = opcode;
                    m_err = !(opcode inside {[6'h04:6'h07]});
                end
            end else begin
                m_age++;
                if (m_err || m_age > 4) begin
                    m_age = 0;
                    m_err = 1'b0;
                end
            end
        end
        e_busy    = (m_age != 0);
        e_alu_op  = (!m_err && m_age == 1) ? 3'b010 : 3'b000;
        e_pcw     = (!m_err && m_age == 3);
        if (e_pcw) e_mux = sel_of(m_op);
        e_done    = (!m_err && m_age == 4);
        e_taken   = e_done ? outcome(m_op, m_flags) : 1'b0;
        e_illegal = (m_err && m_age == 1);
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("m_busy",    {7'd0, busy},        {7'd0, e_busy});
            chk("m_alu_op",  {5'd0, alu_op},      {5'd0, e_alu_op});
            chk("m_pcw",     {7'd0, PCWriteCond}, {7'd0, e_pcw});
            chk("m_mux",     {6'd0, PCWriteCondMux}, {6'd0, e_mux});
            chk("m_done",    {7'd0, done},        {7'd0, e_done});
            chk("m_illegal", {7'd0, illegal},     {7'd0, e_illegal});
            chk("m_flags",   {4'd0, ZeroFio, MaiorFio, MenorFio, IgualFio}, {4'd0, m_flags});
            if (e_done) chk("m_taken", {7'd0, taken}, {7'd0, e_taken});
        end
    end

    // Directed branch with literal expectations; optional second start in FLAGS.
    task automatic run_branch(input logic [5:0] op, input logic [3:0] f,
                              input logic [1:0] xmux, input logic xtaken, input bit restart);
        start = 1'b1;
        opcode = op;
        {alu_zero, alu_gt, alu_lt, alu_eq} = f;
        @(negedge clock);                       // COMPARE
        start = 1'b0;
        chk("cmp_alu_op", {5'd0, alu_op}, 8'h02);
        chk("cmp_busy", {7'd0, busy}, 8'h01);
        @(negedge clock);                       // FLAGS
        chk("flg_alu_op", {5'd0, alu_op}, 8'h00);
        chk("flg_pcw", {7'd0, PCWriteCond}, 8'h00);
        if (restart) begin
            start  = 1'b1;
            opcode = 6'h05;
        end
        @(negedge clock);                       // RESOLVE
        start = 1'b0;
        chk("res_pcw", {7'd0, PCWriteCond}, 8'h01);
        chk("res_mux", {6'd0, PCWriteCondMux}, {6'd0, xmux});
        chk("res_flags", {4'd0, ZeroFio, MaiorFio, MenorFio, IgualFio}, {4'd0, f});
        @(negedge clock);                       // DONE
        chk("dn_done", {7'd0, done}, 8'h01);
        chk("dn_taken", {7'd0, taken}, {7'd0, xtaken});
        chk("dn_pcw", {7'd0, PCWriteCond}, 8'h00);
        chk("dn_busy", {7'd0, busy}, 8'h01);
        repeat (2) begin
            @(negedge clock);                   // IDLE
            chk("idl_busy", {7'd0, busy}, 8'h00);
            chk("idl_done", {7'd0, done}, 8'h00);
            chk("idl_pcw", {7'd0, PCWriteCond}, 8'h00);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opcode = 6'h00;
        {alu_zero, alu_gt, alu_lt, alu_eq} = 4'h0;
        repeat (2) @(negedge clock);
        chk("rst_outputs", {alu_op, PCWriteCondMux, PCWriteCond, busy, done}, 8'h00);
        chk("rst_flags", {2'd0, ZeroFio, MaiorFio, MenorFio, IgualFio, taken, illegal}, 8'h00);
        reset = 1'b0;
        @(negedge clock);

        run_branch(6'h04, 4'b1001, 2'b01, 1'b1, 1'b0);   // BEQ, zero & eq
        run_branch(6'h05, 4'b1000, 2'b00, 1'b0, 1'b0);   // BNE, zero
        run_branch(6'h07, 4'b0100, 2'b10, 1'b1, 1'b0);   // BGT, gt
        run_branch(6'h06, 4'b0001, 2'b11, 1'b1, 1'b0);   // BLE, eq only
        run_branch(6'h06, 4'b0000, 2'b11, 1'b0, 1'b0);   // BLE, no flags
        run_branch(6'h04, 4'b0010, 2'b01, 1'b0, 1'b1);   // BEQ, restart in FLAGS

        // Non-branch opcode
        start = 1'b1;
        opcode = 6'h23;
        @(negedge clock);
        start = 1'b0;
        chk("ill_pulse", {7'd0, illegal}, 8'h01);
        chk("ill_pcw", {7'd0, PCWriteCond}, 8'h00);
        @(negedge clock);
        chk("ill_clear", {7'd0, illegal}, 8'h00);
        chk("ill_busy", {7'd0, busy}, 8'h00);
        chk("ill_pcw2", {7'd0, PCWriteCond}, 8'h00);

        // Reset during FLAGS with BEQ in flight
        start = 1'b1;
        opcode = 6'h04;
        {alu_zero, alu_gt, alu_lt, alu_eq} = 4'b1001;
        @(negedge clock);                       // COMPARE
        start = 1'b0;
        @(negedge clock);                       // FLAGS
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) begin
            chk("abort_ctl", {alu_op, PCWriteCondMux, PCWriteCond, busy, done}, 8'h00);
            chk("abort_flags", {4'd0, ZeroFio, MaiorFio, MenorFio, IgualFio}, 8'h00);
            @(negedge clock);
        end

        // Randomized traffic checked against the model
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 2) == 0);
            opcode = ($urandom_range(0, 3) != 0) ? 6'(4 + $urandom_range(0, 3)) : 6'($urandom);
            {alu_zero, alu_gt, alu_lt, alu_eq} = 4'($urandom);
            @(negedge clock);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_cond_ctrl.md
Name: branch_cond_ctrl

Overview:
Branch-resolution sequencer for the multicycle datapath. It drives the branch-condition select and its enable, and registers the ALU comparison flags that the condition mux consumes. On a start pulse with a branch opcode, it steps through compare, flag-capture and resolve states. It then pulses the PC conditional-write enable with the matching 2-bit select. This is the producer side of the select/flag interface read by the PC write-condition mux.

Parameters:
OP_BEQ, 6'h04, opcode for branch-if-equal
OP_BNE, 6'h05, opcode for branch-if-not-equal
OP_BLE, 6'h06, opcode for branch-if-less-or-equal
OP_BGT, 6'h07, opcode for branch-if-greater
ALU_SUB, 3'b010, ALU operation code driven during compare

Ports:
clock  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
opcode  input  6  instruction opcode; sampled with start
alu_zero  input  1  ALU zero result
alu_gt  input  1  ALU A>B result
alu_lt  input  1  ALU A<B result
alu_eq  input  1  ALU A==B result
alu_op  output  3  ALU operation; ALU_SUB in COMPARE, else 3'b000
PCWriteCondMux  output  2  condition select to PC write-cond mux
PCWriteCond  output  1  conditional PC write enable, one-cycle pulse
ZeroFio  output  1  registered zero flag
MaiorFio  output  1  registered greater flag
MenorFio  output  1  registered less flag
IgualFio  output  1  registered equal flag
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse in DONE
taken  output  1  resolved branch outcome; valid while done=1
illegal  output  1  one-cycle pulse when start carries a non-branch opcode

Behaviour:
- All outputs are registered. Reset (synchronous, dominant over everything) sets the state to IDLE and drives every output and flag register to 0.
- Opcode to select mapping, latched into sel_q at start:
  - BNE -> 2'b00 (not zero)
  - BEQ -> 2'b01 (zero)
  - BGT -> 2'b10 (greater)
  - BLE -> 2'b11 (less OR equal)
- State IDLE:
  - start=1 with a branch opcode -> COMPARE.
  - start=1 with any other opcode -> ERR.
  - Otherwise stay in IDLE.
- State COMPARE: alu_op=ALU_SUB; next state FLAGS.
- State FLAGS: the four alu_* inputs are captured into the flag registers at the end of this cycle; next state RESOLVE.
- State RESOLVE:
  - PCWriteCond=1 and PCWriteCondMux=sel_q for exactly this cycle.
  - taken_q is computed from the captured flags per the mapping: 00 -> ~Zero; 01 -> Zero; 10 -> Maior; 11 -> Menor|Igual.
  - Next state DONE.
- State DONE: done=1, taken=taken_q; next state IDLE.
- State ERR: illegal=1 for one cycle, PCWriteCond stays 0, flags unchanged; next state IDLE.
- Latency: start sampled on edge N; COMPARE in cycle N+1, FLAGS N+2, RESOLVE N+3 (PCWriteCond high), DONE N+4. The next start is accepted in cycle N+5.
- PCWriteCondMux holds its last value outside RESOLVE. PCWriteCond is 0 outside RESOLVE.
- start while busy=1 is ignored, with no queuing.
- Flag registers hold their values until the next FLAGS state or reset.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs 0, and no PCWriteCond or done pulse is emitted for the aborted branch.
- Unused state encodings recover to IDLE on the next clock.
- The alu_* inputs are ignored outside FLAGS.

Test Plan:
- Reset, then start with BEQ, alu_zero=1, alu_eq=1, others 0 -> COMPARE shows alu_op=010; in RESOLVE, PCWriteCond=1 and PCWriteCondMux=01; in DONE, done=1 and taken=1; busy high for 4 cycles.
- Start with BNE, alu_zero=1 -> PCWriteCondMux=00, PCWriteCond pulses once, taken=0.
- Start with BGT, alu_gt=1 -> select 10, taken=1. Repeat with BLE and only alu_eq=1 -> select 11, taken=1. Repeat BLE with all flags 0 -> taken=0.
- Start with opcode 6'h23 -> illegal pulses one cycle after start; PCWriteCond never asserts; back in IDLE the following cycle.
- Second start pulse during FLAGS -> ignored: exactly one done pulse, no extra PCWriteCond.
- Reset asserted in FLAGS, with BEQ in flight -> next cycle IDLE; flags, done and PCWriteCond are all 0 and remain 0 with no pulses afterwards.
